// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operation scheduler.
//   - op codes (bit index into unit_start/unit_done/unit_result)
//   - quiet NaN returned on illegal ops and aborted waits
//   - scheduler state enum
package fpu_pkg;

  localparam int unsigned NUM_UNITS = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_DIV = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;

  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } sched_state_e;

  // Only codes 0..3 map onto a unit.
  function automatic logic op_is_legal(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/fpu_sched_timer.sv
// WAIT-phase cycle counter for the FPU scheduler.
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   clr_i      synchronous clear (takes priority over en_i)
//   en_i       count enable
//   expired_o  high while enabled and the count equals Limit-1
module fpu_sched_timer #(
  parameter int unsigned Limit = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Limit > 2) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/fpu_op_scheduler.sv
// Sequencing controller in front of the add/sub/div/mul FPU units.
// Accepts one request at a time, pulses the selected unit's start, waits for
// its done strobe and returns the result over a valid/ready handshake.
// Operands reach all units over one registered bus, zero outside ISSUE/WAIT.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_a, req_b, req_op     operands and 4-bit op code (4..15 illegal)
//   unit_start               one-hot start pulse, bit = op code
//   unit_a, unit_b           registered operand bus
//   unit_done, unit_result   per-unit done strobes and 32-bit result slices
//   res_valid/res_ready      response handshake
//   res_data, res_op, res_err response payload
//   op_count                 completed responses (wraps)
//
// Optional feature: define FPU_SCHED_TIMEOUT_EN to abort a WAIT after
// TIMEOUT cycles with a qNaN error response.
module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_a,
  input  logic [31:0]            req_b,
  input  logic [3:0]             req_op,
  output logic [NUM_UNITS-1:0]   unit_start,
  output logic [31:0]            unit_a,
  output logic [31:0]            unit_b,
  input  logic [NUM_UNITS-1:0]   unit_done,
  input  logic [32*NUM_UNITS-1:0] unit_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [3:0]             res_op,
  output logic                   res_err,
  output logic [15:0]            op_count
);

  sched_state_e state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [31:0]  a_q, a_d, b_q, b_d;
  logic [31:0]  res_data_q, res_data_d;
  logic         res_err_q, res_err_d;
  logic [15:0]  op_count_q, op_count_d;

  logic         done_hit;
  logic         timeout_hit;
  logic [31:0]  unit_slice;

  // Only ops that passed the legality check reach WAIT, so op_q[1:0] suffices.
  assign done_hit   = unit_done[op_q[1:0]];
  assign unit_slice = unit_result[{op_q[1:0], 5'd0} +: 32];

`ifdef FPU_SCHED_TIMEOUT_EN
  fpu_sched_timer #(
    .Limit (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (state_q != StWait),
    .en_i      (state_q == StWait),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    op_count_d = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d = req_op;
          if (op_is_legal(req_op)) begin
            a_d       = req_a;
            b_d       = req_b;
            res_err_d = 1'b0;
            state_d   = StIssue;
          end else begin
            res_data_d = FPU_QNAN;
            res_err_d  = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // Done takes priority over a coincident timeout.
        if (done_hit) begin
          res_data_d = unit_slice;
          res_err_d  = 1'b0;
          a_d        = '0;
          b_d        = '0;
          state_d    = StResp;
        end else if (timeout_hit) begin
          res_data_d = FPU_QNAN;
          res_err_d  = 1'b1;
          a_d        = '0;
          b_d        = '0;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (res_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign res_valid  = (state_q == StResp);
  assign unit_start = (state_q == StIssue) ? (4'b0001 << op_q[1:0]) : 4'b0000;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign res_data   = res_data_q;
  assign res_op     = op_q;
  assign res_err    = res_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Self-checking bench for fpu_op_scheduler. Expected behaviour comes from a
// cycle-count model of the transaction rules: illegal ops answer one cycle
// after acceptance; legal ops pulse start one cycle after acceptance, then
// answer one cycle after the matching done (or after TIMEOUT wait cycles when
// the timeout feature is compiled in).
module tb_fpu_op_scheduler;

  localparam int unsigned TO = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef FPU_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_a, req_b;
  logic [3:0]   req_op;
  logic [3:0]   unit_start;
  logic [31:0]  unit_a, unit_b;
  logic [3:0]   unit_done;
  logic [127:0] unit_result;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_data;
  logic [3:0]   res_op;
  logic         res_err;
  logic [15:0]  op_count;

  int checks;
  int errors;
  logic [15:0] exp_count;

  fpu_op_scheduler #(
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .unit_start  (unit_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_op      (res_op),
    .res_err     (res_err),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. dly = wait-cycle index at which the unit raises
  // done; wrong = other units strobe done throughout the wait; rdly = cycles
  // the consumer stalls before accepting.
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input int dly, input bit wrong, input int rdly,
                     input logic [31:0] word);
    bit          legal;
    bit          tmo;
    int          exit_idx;
    logic [3:0]  onehot;
    logic [31:0] exp_data;
    logic        exp_err;
    legal  = (op < 4);
    onehot = legal ? (4'b0001 << op[1:0]) : 4'b0000;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);

    if (!legal) begin
      exp_data = QNAN;
      exp_err  = 1'b1;
      checks++;
      if (unit_start !== 4'b0000) begin
        errors++;
        $display("FAIL illegal_start: got %b want 0000", unit_start);
      end
    end else begin
      checks++;
      if ({unit_start, unit_a, unit_b, req_ready, res_valid} !== {onehot, a, b, 2'b00}) begin
        errors++;
        $display("FAIL issue: got start=%b a=%h b=%h rdy=%b vld=%b want start=%b a=%h b=%h 0 0",
                 unit_start, unit_a, unit_b, req_ready, res_valid, onehot, a, b);
      end
      step();
      checks++;
      if (unit_start !== 4'b0000) begin
        errors++;
        $display("FAIL start_pulse_width: got %b want 0000", unit_start);
      end
      tmo      = TO_EN && (dly > int'(TO) - 1);
      exit_idx = tmo ? int'(TO) - 1 : dly;
      for (int i = 0; i <= exit_idx; i++) begin
        unit_result = {$urandom, $urandom, $urandom, $urandom};
        unit_result[int'(op[1:0]) * 32 +: 32] = word;
        unit_done = wrong ? (4'hF & ~onehot) : 4'b0000;
        if (i == dly) unit_done = unit_done | onehot;
        checks++;
        if ({res_valid, unit_a, unit_b} !== {1'b0, a, b}) begin
          errors++;
          $display("FAIL wait_%0d: got vld=%b a=%h b=%h want 0 %h %h",
                   i, res_valid, unit_a, unit_b, a, b);
        end
        step();
      end
      unit_done   = 4'b0000;
      unit_result = {$urandom, $urandom, $urandom, $urandom};
      exp_data    = tmo ? QNAN : word;
      exp_err     = tmo;
    end

    checks++;
    if ({res_valid, res_data, res_err, res_op, unit_a, unit_b} !==
        {1'b1, exp_data, exp_err, op, 64'd0}) begin
      errors++;
      $display("FAIL resp: got vld=%b data=%h err=%b op=%h a=%h b=%h want 1 %h %b %h 0 0",
               res_valid, res_data, res_err, res_op, unit_a, unit_b, exp_data, exp_err, op);
    end

    for (int r = 0; r < rdly; r++) begin
      step();
      checks++;
      if ({res_valid, res_data, res_err, res_op, req_ready, op_count} !==
          {1'b1, exp_data, exp_err, op, 1'b0, exp_count}) begin
        errors++;
        $display("FAIL stall_%0d: got vld=%b data=%h err=%b op=%h rdy=%b cnt=%h want 1 %h %b %h 0 %h",
                 r, res_valid, res_data, res_err, res_op, req_ready, op_count,
                 exp_data, exp_err, op, exp_count);
      end
    end

    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checks++;
    if ({res_valid, req_ready, op_count} !== {2'b01, exp_count}) begin
      errors++;
      $display("FAIL handshake: got vld=%b rdy=%b cnt=%h want 0 1 %h",
               res_valid, req_ready, op_count, exp_count);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({req_ready, res_valid, unit_start, unit_a, unit_b, res_data, res_op, res_err, op_count}
        !== {1'b1, 1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b start=%b a=%h b=%h data=%h op=%h err=%b cnt=%h want 1 0 0 0 0 0 0 0 0",
               tag, req_ready, res_valid, unit_start, unit_a, unit_b, res_data, res_op,
               res_err, op_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_div();
    txn(32'h4080_0000, 32'h4000_0000, 4'd2, 2, 1'b0, 0, 32'h4000_0000);
  endtask

  task automatic test_illegal();
    txn($urandom, $urandom, 4'd7, 0, 1'b0, 0, 32'd0);
    txn($urandom, $urandom, 4'd15, 0, 1'b0, 2, 32'd0);
  endtask

  task automatic test_backpressure();
    txn($urandom, $urandom, 4'd1, 1, 1'b0, 5, $urandom);
  endtask

  task automatic test_wrong_unit();
    txn($urandom, $urandom, 4'd0, 3, 1'b1, 0, $urandom);
  endtask

  // Long wait times out only when the feature is compiled in; done on the
  // last permitted wait cycle must always win.
  task automatic test_timeout();
    txn($urandom, $urandom, 4'd3, 20, 1'b0, 1, $urandom);
    txn($urandom, $urandom, 4'd2, int'(TO) - 1, 1'b0, 0, $urandom);
  endtask

  task automatic test_reset_mid_wait();
    req_a = 32'h1234_5678; req_b = 32'h9abc_def0; req_op = 4'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_wait");
    step();
    rst = 1'b0;
    exp_count = 16'd0;
    txn($urandom, $urandom, 4'd1, 0, 1'b0, 0, $urandom);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      txn($urandom, $urandom, op, $urandom_range(0, 10), 1'($urandom), $urandom_range(0, 3),
          $urandom);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_count   = 16'd0;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_op      = '0;
    unit_done   = '0;
    unit_result = '0;
    res_ready   = 1'b0;

    test_reset();
    test_div();
    test_illegal();
    test_backpressure();
    test_wrong_unit();
    test_timeout();
    test_reset_mid_wait();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
